// File: rtl/qnigma_piso_pkg.sv
// qnigma_piso_pkg -- shared types and helpers for the parallel-in serial-out shifter.
// Parameter-free and width-agnostic. The frame vector type depends on the
// instance's WIDTH and LENGTH, so each module declares it locally.
package qnigma_piso_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } piso_state_t;

    // Limit a requested frame length to the register depth.
    function automatic int unsigned clamp_len(input int unsigned len, input int unsigned max_len);
        return (len > max_len) ? max_len : len;
    endfunction

endpackage

// File: rtl/qnigma_piso_sreg.sv
// qnigma_piso_sreg -- directional shift register for qnigma_piso.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   load         capture par_i, aligned so that the head is at a fixed slot
//   shift        advance the register by one symbol toward the head slot
//   par_i        frame to capture
//   len_i        clamped frame length, 0..LENGTH
//   head_o       current head symbol, taken straight from the register
module qnigma_piso_sreg
    import qnigma_piso_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int LENGTH = 8,
    parameter bit RIGHT  = 1'b0,
    localparam int CW    = $clog2(LENGTH + 1)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           load,
    input  logic                           shift,
    input  logic [LENGTH-1:0][WIDTH-1:0]   par_i,
    input  logic [CW-1:0]                  len_i,
    output logic [WIDTH-1:0]               head_o
);

    typedef logic [LENGTH*WIDTH-1:0] flat_t;

    flat_t sreg_q, sreg_d;
    flat_t par_flat, load_vec, shift_vec;

    assign par_flat = par_i;

    generate
        if (RIGHT == 1'b0) begin : g_left
            // Head is element len-1. Shifting the frame up by the unused slots
            // parks the head in the top slot for every length, so ser_o is
            // always the same register slice.
            assign load_vec  = par_flat << (WIDTH * (LENGTH - int'(len_i)));
            assign shift_vec = sreg_q << WIDTH;
            assign head_o    = sreg_q[LENGTH*WIDTH-1 -: WIDTH];
        end else begin : g_right
            // Head is element 0. Elements at len and above reach the head
            // only after the frame has ended, so they are never emitted.
            assign load_vec  = par_flat;
            assign shift_vec = sreg_q >> WIDTH;
            assign head_o    = sreg_q[WIDTH-1:0];
        end
    endgenerate

    // Load wins over shift: on a back-to-back final beat the old frame is exhausted.
    always_comb begin
        sreg_d = sreg_q;
        if (load) begin
            sreg_d = load_vec;
        end else if (shift) begin
            sreg_d = shift_vec;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sreg_q <= '0;
        end else begin
            sreg_q <= sreg_d;
        end
    end

endmodule

// File: rtl/qnigma_piso.sv
// qnigma_piso -- parallel-in serial-out shifter with valid/ready on both sides.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   par_i        frame to send, sampled on acceptance
//   len_i        symbols in frame (clamped to LENGTH), sampled on acceptance
//   load_val     frame valid
//   load_rdy     frame can be accepted this cycle
//   ser_o        current symbol (registered)
//   ser_val      ser_o valid
//   ser_rdy      sink accepts ser_o
//   ser_last     ser_o is the final symbol of the frame
//   done         one-cycle pulse after the final symbol is accepted
module qnigma_piso
    import qnigma_piso_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int LENGTH = 8,
    parameter bit RIGHT  = 1'b0,
    localparam int CW    = $clog2(LENGTH + 1)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [LENGTH-1:0][WIDTH-1:0]   par_i,
    input  logic [CW-1:0]                  len_i,
    input  logic                           load_val,
    output logic                           load_rdy,
    output logic [WIDTH-1:0]               ser_o,
    output logic                           ser_val,
    input  logic                           ser_rdy,
    output logic                           ser_last,
    output logic                           done
);

    piso_state_t    state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           done_q, done_d;

    logic [CW-1:0]  len_c;
    logic           accept;
    logic           beat;

    assign len_c    = CW'(clamp_len(int'(len_i), LENGTH));
    assign ser_val  = (state_q == SHIFT);
    assign ser_last = (state_q == SHIFT) && (cnt_q == CW'(1));
    assign beat     = ser_val && ser_rdy;
    // A new frame may enter on the accepted final beat, giving gap-free
    // back-to-back frames; load_val is never part of this term.
    assign load_rdy = (state_q == IDLE) || (ser_last && ser_rdy);
    assign accept   = load_val && load_rdy;
    assign done     = done_q;

    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;

        if (beat) begin
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
        end

        if (accept) begin
            if (len_c == '0) begin
                // Empty frame: nothing to send, just acknowledge it.
                done_d  = 1'b1;
                state_d = IDLE;
                cnt_d   = '0;
            end else begin
                state_d = SHIFT;
                cnt_d   = len_c;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    qnigma_piso_sreg #(
        .WIDTH  (WIDTH),
        .LENGTH (LENGTH),
        .RIGHT  (RIGHT)
    ) u_sreg (
        .clk    (clk),
        .rst    (rst),
        .load   (accept),
        .shift  (beat),
        .par_i  (par_i),
        .len_i  (len_c),
        .head_o (ser_o)
    );

endmodule

// File: tb/tb_qnigma_piso.sv
// tb_qnigma_piso -- directed bench for qnigma_piso with LENGTH=4, WIDTH=8.
// Two instances share the frame inputs: dut0 with RIGHT=0, dut1 with RIGHT=1.
module tb_qnigma_piso;

    localparam int W  = 8;
    localparam int L  = 4;
    localparam int CW = $clog2(L + 1);

    logic                 clk = 1'b0;
    logic                 rst;
    logic [L-1:0][W-1:0]  par_i;
    logic [CW-1:0]        len_i;
    logic                 ser_rdy;
    logic                 load_val0, load_val1;
    logic                 load_rdy0, load_rdy1;
    logic [W-1:0]         ser_o0, ser_o1;
    logic                 ser_val0, ser_val1;
    logic                 ser_last0, ser_last1;
    logic                 done0, done1;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    always #5 clk = ~clk;

    qnigma_piso #(.WIDTH(W), .LENGTH(L), .RIGHT(1'b0)) dut0 (
        .clk(clk), .rst(rst), .par_i(par_i), .len_i(len_i),
        .load_val(load_val0), .load_rdy(load_rdy0),
        .ser_o(ser_o0), .ser_val(ser_val0), .ser_rdy(ser_rdy),
        .ser_last(ser_last0), .done(done0)
    );

    qnigma_piso #(.WIDTH(W), .LENGTH(L), .RIGHT(1'b1)) dut1 (
        .clk(clk), .rst(rst), .par_i(par_i), .len_i(len_i),
        .load_val(load_val1), .load_rdy(load_rdy1),
        .ser_o(ser_o1), .ser_val(ser_val1), .ser_rdy(ser_rdy),
        .ser_last(ser_last1), .done(done1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [W-1:0]        exp_sym [4];
        logic [L-1:0][W-1:0] rec;
        logic [L-1:0][W-1:0] mask;
        logic [0:9]          rdy_pat;
        int                  idx;
        int                  beats;
        int                  flen;

        rst = 1'b1; par_i = '0; len_i = '0; ser_rdy = 1'b0;
        load_val0 = 1'b0; load_val1 = 1'b0;
        tick(); tick();

        // Reset state.
        check("rst_ser_val",  32'(ser_val0),  32'd0);
        check("rst_ser_o",    32'(ser_o0),    32'd0);
        check("rst_ser_last", 32'(ser_last0), 32'd0);
        check("rst_done",     32'(done0),     32'd0);
        check("rst_load_rdy", 32'(load_rdy0), 32'd1);
        rst = 1'b0;

        // Basic order, RIGHT=0: D3,C2,B1,A0.
        par_i = {8'hD3, 8'hC2, 8'hB1, 8'hA0}; len_i = 3'd4; ser_rdy = 1'b1;
        load_val0 = 1'b1;
        check("basic_load_rdy", 32'(load_rdy0), 32'd1);
        tick();
        load_val0 = 1'b0; par_i = '0; len_i = '0;
        exp_sym = '{8'hD3, 8'hC2, 8'hB1, 8'hA0};
        for (int i = 0; i < 4; i++) begin
            check($sformatf("basic_sym%0d", i),  32'(ser_o0),    32'(exp_sym[i]));
            check($sformatf("basic_val%0d", i),  32'(ser_val0),  32'd1);
            check($sformatf("basic_last%0d", i), 32'(ser_last0), 32'(i == 3));
            tick();
        end
        check("basic_done",     32'(done0),    32'd1);
        check("basic_idle_val", 32'(ser_val0), 32'd0);
        tick();
        check("basic_done_pulse", 32'(done0), 32'd0);

        // RIGHT=1, len 3: A0,B1,C2 and element 3 never appears.
        par_i = {8'hD3, 8'hC2, 8'hB1, 8'hA0}; len_i = 3'd3;
        load_val1 = 1'b1;
        tick();
        load_val1 = 1'b0; par_i = '0;
        exp_sym = '{8'hA0, 8'hB1, 8'hC2, 8'h00};
        for (int i = 0; i < 3; i++) begin
            check($sformatf("right_sym%0d", i),  32'(ser_o1),    32'(exp_sym[i]));
            check($sformatf("right_last%0d", i), 32'(ser_last1), 32'(i == 2));
            tick();
        end
        check("right_done",     32'(done1),    32'd1);
        check("right_idle_val", 32'(ser_val1), 32'd0);

        // Backpressure: symbols hold while ser_rdy=0; exactly 4 accepted beats.
        par_i = {8'hD3, 8'hC2, 8'hB1, 8'hA0}; len_i = 3'd4;
        load_val0 = 1'b1;
        tick();
        load_val0 = 1'b0; par_i = '0;
        exp_sym = '{8'hD3, 8'hC2, 8'hB1, 8'hA0};
        rdy_pat = 10'b1001101011;
        idx = 0; beats = 0;
        for (int k = 0; k < 10 && idx < 4; k++) begin
            ser_rdy = rdy_pat[k];
            check($sformatf("bp_val_c%0d", k),  32'(ser_val0),  32'd1);
            check($sformatf("bp_sym_c%0d", k),  32'(ser_o0),    32'(exp_sym[idx]));
            check($sformatf("bp_last_c%0d", k), 32'(ser_last0), 32'(idx == 3));
            if (ser_val0 && ser_rdy) begin
                beats++;
                idx++;
            end
            tick();
        end
        ser_rdy = 1'b1;
        check("bp_beats", 32'(beats),    32'd4);
        check("bp_done",  32'(done0),    32'd1);
        check("bp_idle",  32'(ser_val0), 32'd0);

        // Back-to-back len 2 frames: 12,34 then 22,11 with no gap.
        par_i = {8'h00, 8'h00, 8'h12, 8'h34}; len_i = 3'd2;
        load_val0 = 1'b1;
        tick();
        load_val0 = 1'b1;   // held high: must stall until the final beat
        par_i = {8'h00, 8'h00, 8'h22, 8'h11};
        check("b2b_sym0",     32'(ser_o0),    32'h12);
        check("b2b_stall",    32'(load_rdy0), 32'd0);
        tick();
        check("b2b_sym1",     32'(ser_o0),    32'h34);
        check("b2b_last1",    32'(ser_last0), 32'd1);
        check("b2b_rdy_last", 32'(load_rdy0), 32'd1);
        tick();
        load_val0 = 1'b0; par_i = '0;
        check("b2b_no_bubble", 32'(ser_val0), 32'd1);
        check("b2b_sym2",      32'(ser_o0),   32'h22);
        check("b2b_done1",     32'(done0),    32'd1);
        tick();
        check("b2b_sym3",  32'(ser_o0),    32'h11);
        check("b2b_last3", 32'(ser_last0), 32'd1);
        check("b2b_mid",   32'(done0),     32'd0);
        tick();
        check("b2b_done2", 32'(done0),    32'd1);
        check("b2b_idle",  32'(ser_val0), 32'd0);
        tick();

        // len 0: discarded, done pulse, no ser_val.
        par_i = {8'hD3, 8'hC2, 8'hB1, 8'hA0}; len_i = 3'd0;
        load_val0 = 1'b1;
        tick();
        load_val0 = 1'b0;
        check("len0_val",  32'(ser_val0),  32'd0);
        check("len0_done", 32'(done0),     32'd1);
        check("len0_rdy",  32'(load_rdy0), 32'd1);
        tick();
        check("len0_done_pulse", 32'(done0), 32'd0);

        // len 7 on LENGTH 4: clamped to exactly 4 symbols.
        len_i = 3'd7;
        load_val0 = 1'b1;
        tick();
        load_val0 = 1'b0; par_i = '0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("clamp_sym%0d", i),  32'(ser_o0),    32'(exp_sym[i]));
            check($sformatf("clamp_last%0d", i), 32'(ser_last0), 32'(i == 3));
            tick();
        end
        check("clamp_end",  32'(ser_val0), 32'd0);
        check("clamp_done", 32'(done0),    32'd1);

        // len 1: single beat carrying ser_last.
        par_i = {8'hD3, 8'hC2, 8'hB1, 8'hA0}; len_i = 3'd1;
        load_val0 = 1'b1;
        tick();
        load_val0 = 1'b0;
        check("len1_sym",  32'(ser_o0),    32'hA0);
        check("len1_last", 32'(ser_last0), 32'd1);
        tick();
        check("len1_done", 32'(done0), 32'd1);

        // Mid-frame reset after 2 of 4 beats.
        len_i = 3'd4;
        load_val0 = 1'b1;
        tick();
        load_val0 = 1'b0;
        tick(); tick();
        check("mrst_pre_sym", 32'(ser_o0), 32'hB1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mrst_val",  32'(ser_val0),  32'd0);
        check("mrst_done", 32'(done0),     32'd0);
        check("mrst_rdy",  32'(load_rdy0), 32'd1);
        par_i = {8'h44, 8'h33, 8'h22, 8'h11};
        load_val0 = 1'b1;
        tick();
        load_val0 = 1'b0;
        check("mrst_new0", 32'(ser_o0), 32'h44);
        tick();
        check("mrst_new1", 32'(ser_o0), 32'h33);
        tick(); tick(); tick();
        check("mrst_no_done_leak", 32'(ser_val0), 32'd0);

        // Loopback into a SIPO model with random frames and random ser_rdy.
        for (int f = 0; f < 6; f++) begin
            par_i = {W'($urandom), W'($urandom), W'($urandom), W'($urandom)};
            flen  = int'($urandom_range(1, 4));
            len_i = CW'(flen);
            if (f % 2 == 0) load_val0 = 1'b1; else load_val1 = 1'b1;
            tick();
            load_val0 = 1'b0; load_val1 = 1'b0;
            rec = '0; beats = 0;
            for (int c = 0; c < 100 && beats < flen; c++) begin
                ser_rdy = 1'($urandom_range(0, 1));
                if (f % 2 == 0) begin
                    if (ser_val0 && ser_rdy) begin
                        rec[flen-1-beats] = ser_o0;
                        beats++;
                    end
                end else begin
                    if (ser_val1 && ser_rdy) begin
                        rec[beats] = ser_o1;
                        beats++;
                    end
                end
                tick();
            end
            ser_rdy = 1'b1;
            mask = '0;
            for (int e = 0; e < flen; e++) mask[e] = '1;
            check($sformatf("loop%0d_beats", f), 32'(beats), 32'(flen));
            check($sformatf("loop%0d_data", f), 32'(rec & mask), 32'(par_i & mask));
            par_i = '0;
            tick();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/qnigma_piso.md
Name: qnigma_piso

Overview:
- Parallel-in serial-out shifter with valid/ready handshakes on both sides; the transmit counterpart of the team's serial-in parallel-out register.
- Accepts a frame of up to LENGTH symbols of WIDTH bits, then emits them one per accepted beat, in the order that the matching SIPO (same RIGHT setting) reassembles into the original vector.
- Used wherever a wide register value must be streamed over a narrow datapath.

Parameters:
- WIDTH, 8, bits per symbol.
- LENGTH, 8, max symbols per frame (>=2).
- RIGHT, 0, emission order: 0 = index len-1 down to 0; 1 = index 0 up to len-1.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- par_i  in  [LENGTH-1:0][WIDTH-1:0]  frame to send.
- len_i  in  $clog2(LENGTH+1)  symbols in frame; sampled at load.
- load_val  in  1  frame valid.
- load_rdy  out  1  block can accept a frame this cycle.
- ser_o  out  WIDTH  current symbol.
- ser_val  out  1  ser_o valid.
- ser_rdy  in  1  sink accepts ser_o.
- ser_last  out  1  ser_o is the final symbol of the frame.
- done  out  1  one-cycle pulse after the final symbol is accepted.

Behaviour:
- Reset clears all of the following to 0 and aborts any frame in progress; the partially sent frame is dropped with no done pulse:
  - Outputs: ser_o, ser_val, ser_last, done.
  - Internals: shift register, remaining-count, state.
- load_rdy is 1 after reset, so the first frame can be accepted in the cycle after rst deasserts.
- States:
  - IDLE: ser_val=0, load_rdy=1.
  - SHIFT: ser_val=1.
- Load:
  - A frame is accepted when load_val && load_rdy.
  - The shift register captures par_i; cnt = clamp(len_i).
  - The next state is SHIFT, so ser_val rises the cycle after acceptance (latency 1).
- Length rules:
  - len_i > LENGTH is clamped to LENGTH.
  - len_i == 0 is accepted and discarded: no ser_val, done pulses the next cycle, state stays IDLE.
- Head symbol:
  - RIGHT=0: the head is element len-1 at load; each beat shifts toward higher indices (left).
  - RIGHT=1: the head is element 0; each beat shifts right.
  - ser_o always reflects the current head and is registered (no combinational path from par_i).
- Beat: on ser_val && ser_rdy the register shifts by one symbol and cnt decrements. ser_o, ser_val and ser_last hold stable while ser_rdy=0 (AXI-style: no retraction).
- ser_last = (cnt == 1) while in SHIFT.
- End of frame: when the ser_last beat is accepted, done=1 the following cycle.
- load_rdy in SHIFT:
  - load_rdy=1 only during the ser_last beat with ser_rdy=1, which allows back-to-back frames with no bubble.
  - If load_val is then high, the new frame loads and the state stays SHIFT; otherwise the state returns to IDLE.
- load_rdy depends combinationally on ser_rdy only in that final-beat case; it never depends on load_val.
- par_i and len_i are ignored except in the acceptance cycle.
- len_i == 1 gives a one-beat frame with ser_last=1 on its only beat.
- No other state; load_val during SHIFT (not on the final beat) is stalled, not lost.

Decomposition:
- Put the state enum (IDLE, SHIFT) and the symbol-vector typedef in a shared qnigma_piso_pkg; the package is parameter-free and width-agnostic.
- Keep the state machine and the counter in this module.
- Factor the directional shift register (load, shift-by-one, head select by RIGHT) into one sub-module, qnigma_piso_sreg, mirroring the generate split of the SIPO.

Test Plan:
- Basic order, RIGHT=0, LENGTH=4, WIDTH=8:
  - Stimulus: par_i={8'hD3,8'hC2,8'hB1,8'hA0}, len_i=4, ser_rdy=1.
  - Response: ser_o D3,C2,B1,A0 on consecutive cycles starting 1 cycle after load; ser_last on A0; done one cycle later.
- RIGHT=1 with the same par_i and len_i=3 -> ser_o A0,B1,C2; ser_last on C2; element 3 never emitted.
- Backpressure:
  - Stimulus: ser_rdy toggles 1,0,0,1,1,...
  - Response: ser_o holds each symbol while ser_rdy=0; the sequence is unchanged; exactly 4 accepted beats.
- Back-to-back, len_i=2 each:
  - Stimulus: second frame {..,8'h22,8'h11} presented during the last beat of the first.
  - Response: no idle cycle between frames; done pulses twice.
- Length edge cases:
  - len_i=0 -> no ser_val, done pulse.
  - len_i=7 with LENGTH=4 -> exactly 4 symbols.
- Mid-frame reset:
  - Stimulus: rst asserted after 2 of 4 beats.
  - Response next cycle: ser_val=0, done=0, load_rdy=1; the next frame sends from its first symbol.
  - Loopback property into a matching SIPO with random frames and random ser_rdy -> recovered vector equals par_i.
